// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Owns the PC, keeps at most one read outstanding to instruction memory, and
// parks each returned word with its PC in a one-entry buffer that feeds the
// IF/ID register. A redirect from EX retargets the PC. If a read is already in
// flight when the redirect arrives, that read is squashed: the request is held
// until its response arrives, and the response is then discarded.
module fetch_stage #(
    parameter int unsigned      width  = 32,
    parameter logic [width-1:0] rst_pc = 32'h40000000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_read,
    output logic [width-1:0] imem_address,
    input  logic [width-1:0] imem_rdata,
    input  logic             imem_resp,
    input  logic             stall,
    input  logic             redirect,
    input  logic [width-1:0] redirect_pc,
    output logic             out_valid,
    output logic [width-1:0] out_pc,
    output logic [width-1:0] out_ir
);

    // WAIT: no read outstanding. FETCH: live read. SQUASH: read whose data is unwanted.
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [width-1:0] pc_q,        pc_d;
    logic [width-1:0] req_addr_q,  req_addr_d;
    logic             buf_valid_q, buf_valid_d;
    logic [width-1:0] buf_pc_q,    buf_pc_d;
    logic [width-1:0] buf_ir_q,    buf_ir_d;

    logic [width-1:0] redirect_tgt;
    logic             consume;

    // Targets are always word aligned; the low two bits of the EX target are dropped.
    assign redirect_tgt = {redirect_pc[width-1:2], 2'b00};
    assign consume      = buf_valid_q && !stall;

    assign imem_read    = (state_q == FETCH) || (state_q == SQUASH);
    assign imem_address = req_addr_q;
    assign out_valid    = buf_valid_q;
    assign out_pc       = buf_pc_q;
    assign out_ir       = buf_ir_q;

    // Next-state logic: request sequencing, PC update and buffer fill/drain.
    always_comb begin
        // NOTE: every _d starts from its _q value, so no path leaves one unassigned (no latch).
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_ir_d    = buf_ir_q;

        if (consume) begin
            buf_valid_d = 1'b0;
        end

        // A redirect outranks both stall and any returning data.
        if (redirect) begin
            buf_valid_d = 1'b0;
            pc_d        = redirect_tgt;
        end

        case (state_q)
            WAIT: begin
                // Stray response strobes are ignored here.
                if (redirect) begin
                    state_d    = FETCH;
                    req_addr_d = redirect_tgt;
                end else if (!buf_valid_q || consume) begin
                    state_d    = FETCH;
                    req_addr_d = pc_q;
                end
            end
            FETCH: begin
                if (imem_resp) begin
                    if (redirect) begin
                        // Data is stale. Start the redirected read immediately.
                        req_addr_d = redirect_tgt;
                    end else begin
                        // The buffer is always free here: FETCH is only entered once it has drained.
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_addr_q;
                        buf_ir_d    = imem_rdata;
                        pc_d        = req_addr_q + width'(4);
                        state_d     = WAIT;
                    end
                end else if (redirect) begin
                    // The address must stay stable until the memory responds.
                    state_d = SQUASH;
                end
            end
            SQUASH: begin
                // The dead read completes. Refetch from the newest PC (the last redirect wins).
                if (imem_resp) begin
                    state_d    = FETCH;
                    req_addr_d = redirect ? redirect_tgt : pc_q;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // State registers with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
        if (rst) begin
            state_q     <= WAIT;
            pc_q        <= rst_pc;
            req_addr_q  <= rst_pc;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_ir_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_ir_q    <= buf_ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage.
// The reference model is transaction level. It tracks whether a read is
// outstanding, whether that read has been squashed, the architectural PC and
// the one-entry output buffer. It is updated from the fetch rules once per
// cycle. A directed prologue is followed by a randomized run against a
// variable-latency memory.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h40000000;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_ir;

    fetch_stage #(.width(32), .rst_pc(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_ir       (out_ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, as seen after the most recent clock edge.
    bit          m_out;
    bit          m_poison;
    bit          m_bv;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_bpc;
    logic [31:0] m_bir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_model();
        check("model_read", imem_read, m_out);
        if (m_out) check("model_addr", imem_address, m_addr);
        check("model_valid", out_valid, m_bv);
        if (m_bv) begin
            check("model_pc", out_pc, m_bpc);
            check("model_ir", out_ir, m_bir);
        end
    endtask

    // One clock cycle: drive the inputs, advance the model, then compare at the falling edge.
    task automatic step(input bit i_rst, input bit i_resp, input logic [31:0] i_rdata,
                        input bit i_stall, input bit i_redir, input logic [31:0] i_rpc);
        bit          n_out;
        bit          n_poison;
        bit          n_bv;
        logic [31:0] n_addr;
        logic [31:0] n_pc;
        logic [31:0] n_bpc;
        logic [31:0] n_bir;
        logic [31:0] tgt;
        bit          consumed;
        bit          got;
        bit          keep;

        rst         = i_rst;
        imem_resp   = i_resp;
        imem_rdata  = i_rdata;
        stall       = i_stall;
        redirect    = i_redir;
        redirect_pc = i_rpc;

        n_out = m_out; n_poison = m_poison; n_bv = m_bv;
        n_addr = m_addr; n_pc = m_pc; n_bpc = m_bpc; n_bir = m_bir;
        tgt = i_rpc & ~32'd3;

        if (i_rst) begin
            n_out = 0; n_poison = 0; n_bv = 0;
            n_bpc = '0; n_bir = '0; n_pc = RST_PC; n_addr = RST_PC;
        end else begin
            consumed = m_bv && !i_stall;
            got      = m_out && i_resp;
            keep     = got && !m_poison && !i_redir;

            if (i_redir) n_bv = 0;
            else if (keep) begin n_bv = 1; n_bpc = m_addr; n_bir = i_rdata; end
            else if (consumed) n_bv = 0;

            if (i_redir) n_pc = tgt;
            else if (keep) n_pc = m_addr + 32'd4;

            if (m_out && !got) begin
                n_poison = m_poison || i_redir;
            end else if (got) begin
                if (keep) n_out = 0;
                else begin n_out = 1; n_addr = n_pc; n_poison = 0; end
            end else if (i_redir || !m_bv || consumed) begin
                n_out = 1; n_addr = n_pc; n_poison = 0;
            end
        end

        m_out = n_out; m_poison = n_poison; m_bv = n_bv;
        m_addr = n_addr; m_pc = n_pc; m_bpc = n_bpc; m_bir = n_bir;

        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input bit i_stall);
        step(0, 0, 32'h0, i_stall, 0, 32'h0);
    endtask

    bit          busy;
    int          lat;
    bit          r_rst;
    bit          r_resp;
    logic [31:0] r_rpc;

    initial begin
        rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);

        // Reset, then the first fetch goes out one idle cycle later.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_read", imem_read, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        idle(0);
        check("first_read", imem_read, 1'b1);
        check("first_addr", imem_address, 32'h40000000);

        // Sequential fetch with a memory that responds at once.
        step(0, 1, 32'h00500013, 0, 0, 0);
        check("seq0_pc", out_pc, 32'h40000000);
        check("seq0_ir", out_ir, 32'h00500013);
        check("seq0_read", imem_read, 1'b0);
        idle(0);
        check("seq1_addr", imem_address, 32'h40000004);
        step(0, 1, 32'h00A00093, 0, 0, 0);
        check("seq1_pc", out_pc, 32'h40000004);

        // The buffer holds through a stall, and no new fetch starts meanwhile.
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("stall_pc", out_pc, 32'h40000004);
            check("stall_ir", out_ir, 32'h00A00093);
            check("stall_read", imem_read, 1'b0);
        end
        idle(0);
        check("unstall_read", imem_read, 1'b1);
        check("unstall_addr", imem_address, 32'h40000008);

        // A redirect while a read is outstanding squashes that read.
        step(0, 0, 0, 0, 1, 32'h40000100);
        check("squash_hold0", imem_address, 32'h40000008);
        idle(0);
        idle(0);
        check("squash_hold2", imem_address, 32'h40000008);
        step(0, 1, 32'hDEADBEEF, 0, 0, 0);
        check("squash_valid", out_valid, 1'b0);
        check("squash_next", imem_address, 32'h40000100);

        // A redirect in the same cycle as the response.
        step(0, 1, 32'h0BADC0DE, 0, 1, 32'h40000200);
        check("coinc_valid", out_valid, 1'b0);
        check("coinc_addr", imem_address, 32'h40000200);

        // Two redirects during SQUASH: the last one wins.
        step(0, 0, 0, 0, 1, 32'h40000300);
        step(0, 0, 0, 0, 1, 32'h40000400);
        check("dbl_hold", imem_address, 32'h40000200);
        step(0, 1, 32'h11111111, 0, 0, 0);
        check("dbl_addr", imem_address, 32'h40000400);
        step(0, 1, 32'h22222222, 0, 0, 0);
        check("dbl_pc", out_pc, 32'h40000400);

        // A misaligned target is aligned down, and a redirect flushes a stalled buffer.
        step(0, 0, 0, 1, 1, 32'h40000402);
        check("align_valid", out_valid, 1'b0);
        check("align_addr", imem_address, 32'h40000400);

        // A stray response in WAIT is ignored. Reset with a full buffer clears everything.
        step(0, 1, 32'h33333333, 0, 0, 0);
        step(0, 1, 32'h44444444, 1, 0, 0);
        check("stray_ir", out_ir, 32'h33333333);
        step(1, 0, 0, 1, 0, 0);
        check("rstmid_valid", out_valid, 1'b0);
        check("rstmid_read", imem_read, 1'b0);
        idle(0);
        check("rstmid_addr", imem_address, 32'h40000000);

        // Reset while in FETCH.
        step(1, 0, 0, 0, 0, 0);
        check("rstf_read", imem_read, 1'b0);
        idle(0);
        check("rstf_addr", imem_address, 32'h40000000);

        // The PC wraps from the top of the address space to zero.
        step(0, 1, 32'h0, 0, 1, 32'hFFFFFFFF);
        check("wrap_tgt", imem_address, 32'hFFFFFFFC);
        step(0, 1, 32'h55555555, 0, 0, 0);
        check("wrap_pc", out_pc, 32'hFFFFFFFC);
        idle(0);
        check("wrap_addr", imem_address, 32'h00000000);

        // Randomized run against a memory with 0..3 cycles of latency.
        busy = 0;
        lat  = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rst  = ($urandom_range(0, 299) == 0);
            r_resp = 0;
            if (imem_read) begin
                if (!busy) begin
                    busy = 1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    r_resp = 1;
                    busy   = 0;
                end else begin
                    lat--;
                end
            end else begin
                r_resp = ($urandom_range(0, 19) == 0);
            end
            if (r_rst) busy = 0;
            r_rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                               : 32'($urandom);
            step(r_rst, r_resp, 32'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0), r_rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
